// File: rtl/pixgen_pkg.sv
// Geometry and colour defaults plus the sprite state type shared by the
// bouncing-sprite pixel generators.
package pixgen_pkg;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_SIZE     = 64;
   localparam int DEF_COORD_W  = 10;
   localparam int DEF_VEL_W    = 4;
   localparam int DEF_RGB_W    = 12;

   localparam logic [11:0] DEF_BG_RGB = 12'hF00;
   // Colours for up to eight sprites, sprite 0 in the LSBs.
   localparam logic [95:0] DEF_SPRITE_RGB = {12'hF80, 12'h888, 12'h00F, 12'hFFF,
                                             12'hF0F, 12'hFF0, 12'h0F0, 12'h0FF};

   typedef struct packed {
      logic [DEF_COORD_W-1:0]     px;
      logic [DEF_COORD_W-1:0]     py;
      logic signed [DEF_VEL_W-1:0] vx;
      logic signed [DEF_VEL_W-1:0] vy;
   } sprite_state_t;
endpackage

// File: rtl/sprite_axis_step.sv
// One-axis motion step: advance a coordinate by a signed velocity and
// reflect off 0 or max, clamping the coordinate onto the edge it hit.
module sprite_axis_step #(
   parameter int COORD_W = 10,
   parameter int VEL_W   = 4
) (
   input  logic [COORD_W-1:0] p_i,
   input  logic [VEL_W-1:0]   v_i,
   input  logic [COORD_W-1:0] max_i,
   output logic [COORD_W-1:0] p_next_o,
   output logic [VEL_W-1:0]   v_next_o,
   output logic               reflected_o
);
   logic signed [COORD_W:0] p_s, v_s, max_s, n_s;
   logic                    v_neg, v_pos;

   assign p_s   = signed'({1'b0, p_i});
   assign max_s = signed'({1'b0, max_i});
   assign v_s   = signed'({{(COORD_W+1-VEL_W){v_i[VEL_W-1]}}, v_i});
   assign n_s   = p_s + v_s;
   assign v_neg = v_i[VEL_W-1];
   assign v_pos = !v_neg && (v_i != '0);

   always_comb begin
      p_next_o    = n_s[COORD_W-1:0];
      v_next_o    = v_i;
      reflected_o = 1'b0;
      if (v_neg && (n_s < 0)) begin
         p_next_o    = '0;
         v_next_o    = '0 - v_i;
         reflected_o = 1'b1;
      end else if (v_pos && (n_s > max_s)) begin
         p_next_o    = max_i;
         v_next_o    = '0 - v_i;
         reflected_o = 1'b1;
      end
   end
endmodule

// File: rtl/multi_sprite_bounce.sv
// N independent bouncing squares over a fixed background, with registered RGB,
// run/pause/single-step control, runtime sprite configuration and bounce events.
module multi_sprite_bounce
   import pixgen_pkg::*;
#(
   parameter int N_SPRITES = 4,
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int SIZE      = DEF_SIZE,
   parameter int COORD_W   = DEF_COORD_W,
   parameter int VEL_W     = DEF_VEL_W,
   parameter int RGB_W     = DEF_RGB_W,
   parameter logic [RGB_W-1:0]           BG_RGB     = DEF_BG_RGB,
   parameter logic [N_SPRITES*RGB_W-1:0] SPRITE_RGB = DEF_SPRITE_RGB[N_SPRITES*RGB_W-1:0],
   parameter int TICK_Y    = 481
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 video_on,
   input  logic [COORD_W-1:0]   x,
   input  logic [COORD_W-1:0]   y,
   input  logic                 pause,
   input  logic                 step,
   input  logic                 cfg_we,
   input  logic [2:0]           cfg_idx,
   input  logic [COORD_W-1:0]   cfg_x,
   input  logic [COORD_W-1:0]   cfg_y,
   input  logic [VEL_W-1:0]     cfg_vx,
   input  logic [VEL_W-1:0]     cfg_vy,
   output logic [RGB_W-1:0]     rgb,
   output logic [N_SPRITES-1:0] bounce_evt,
   output logic [15:0]          frame_cnt
);
   localparam logic [COORD_W-1:0] MAX_X   = COORD_W'(H_ACTIVE - SIZE);
   localparam logic [COORD_W-1:0] MAX_Y   = COORD_W'(V_ACTIVE - SIZE);
   localparam logic [COORD_W:0]   SIZE_W  = (COORD_W+1)'(SIZE);
   localparam logic [VEL_W-1:0]   VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};
   localparam int                 VEL_MAXI = (1 << (VEL_W-1)) - 1;

   function automatic logic [COORD_W-1:0] clamp_pos(input logic [COORD_W-1:0] p,
                                                    input logic [COORD_W-1:0] mx);
      return (p > mx) ? mx : p;
   endfunction

   // The most negative velocity has no positive mirror, so it is pulled in by one.
   function automatic logic [VEL_W-1:0] sat_vel(input logic [VEL_W-1:0] v);
      return (v == VEL_MIN) ? VEL_MIN + 1'b1 : v;
   endfunction

   function automatic logic [COORD_W-1:0] init_px(input int i);
      int p;
      p = i * (SIZE + 16);
      return (p > H_ACTIVE - SIZE) ? MAX_X : COORD_W'(p);
   endfunction

   function automatic logic [COORD_W-1:0] init_py(input int i);
      int p;
      p = i * 32;
      return (p > V_ACTIVE - SIZE) ? MAX_Y : COORD_W'(p);
   endfunction

   // Sprite i starts at speed i+1, held to the largest representable velocity.
   function automatic logic [VEL_W-1:0] init_vx(input int i);
      return (i + 1 > VEL_MAXI) ? VEL_W'(VEL_MAXI) : VEL_W'(i + 1);
   endfunction

   function automatic logic [VEL_W-1:0] init_vy(input int i);
      return (i % 2 == 0) ? VEL_W'(2) : VEL_W'(-2);
   endfunction

   logic [COORD_W-1:0]   px_q [N_SPRITES], px_d [N_SPRITES], px_nx [N_SPRITES];
   logic [COORD_W-1:0]   py_q [N_SPRITES], py_d [N_SPRITES], py_nx [N_SPRITES];
   logic [VEL_W-1:0]     vx_q [N_SPRITES], vx_d [N_SPRITES], vx_nx [N_SPRITES];
   logic [VEL_W-1:0]     vy_q [N_SPRITES], vy_d [N_SPRITES], vy_nx [N_SPRITES];
   logic [N_SPRITES-1:0] rx, ry, cfg_sel, hit;
   logic [N_SPRITES-1:0] bounce_q, bounce_d;
   logic [15:0]          frame_q, frame_d;
   logic                 step_pending_q, step_pending_d;
   logic [RGB_W-1:0]     rgb_q, rgb_d;
   logic                 tick, apply;
   logic [COORD_W-1:0]   cfg_x_c, cfg_y_c;
   logic [VEL_W-1:0]     cfg_vx_s, cfg_vy_s;

   assign tick     = (x == '0) && (y == COORD_W'(TICK_Y));
   assign apply    = tick && (!pause || step_pending_q);
   assign frame_d  = apply ? frame_q + 16'd1 : frame_q;
   assign cfg_x_c  = clamp_pos(cfg_x, MAX_X);
   assign cfg_y_c  = clamp_pos(cfg_y, MAX_Y);
   assign cfg_vx_s = sat_vel(cfg_vx);
   assign cfg_vy_s = sat_vel(cfg_vy);

   always_comb begin
      step_pending_d = step_pending_q;
      if (!pause || apply) step_pending_d = 1'b0;
      else if (step)       step_pending_d = 1'b1;
   end

   for (genvar i = 0; i < N_SPRITES; i++) begin : g_sprite
      sprite_axis_step #(.COORD_W(COORD_W), .VEL_W(VEL_W)) u_x (
         .p_i(px_q[i]), .v_i(vx_q[i]), .max_i(MAX_X),
         .p_next_o(px_nx[i]), .v_next_o(vx_nx[i]), .reflected_o(rx[i]));
      sprite_axis_step #(.COORD_W(COORD_W), .VEL_W(VEL_W)) u_y (
         .p_i(py_q[i]), .v_i(vy_q[i]), .max_i(MAX_Y),
         .p_next_o(py_nx[i]), .v_next_o(vy_nx[i]), .reflected_o(ry[i]));

      assign cfg_sel[i] = cfg_we && (cfg_idx == 3'(i));
      // One extra bit keeps px+SIZE from wrapping near the top of the coordinate range.
      assign hit[i] = ({1'b0, x} >= {1'b0, px_q[i]}) && ({1'b0, x} < {1'b0, px_q[i]} + SIZE_W) &&
                      ({1'b0, y} >= {1'b0, py_q[i]}) && ({1'b0, y} < {1'b0, py_q[i]} + SIZE_W);
   end

   // A configuration write overrides the motion update on every field and hides its bounce.
   always_comb begin
      for (int i = 0; i < N_SPRITES; i++) begin
         px_d[i]     = px_q[i];
         py_d[i]     = py_q[i];
         vx_d[i]     = vx_q[i];
         vy_d[i]     = vy_q[i];
         bounce_d[i] = 1'b0;
         if (cfg_sel[i]) begin
            px_d[i] = cfg_x_c;
            py_d[i] = cfg_y_c;
            vx_d[i] = cfg_vx_s;
            vy_d[i] = cfg_vy_s;
         end else if (apply) begin
            px_d[i]     = px_nx[i];
            py_d[i]     = py_nx[i];
            vx_d[i]     = vx_nx[i];
            vy_d[i]     = vy_nx[i];
            bounce_d[i] = rx[i] | ry[i];
         end
      end
   end

   always_comb begin
      rgb_d = BG_RGB;
      for (int i = N_SPRITES - 1; i >= 0; i--) begin
         if (hit[i]) rgb_d = SPRITE_RGB[i*RGB_W +: RGB_W];
      end
      if (!video_on) rgb_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_SPRITES; i++) begin
            px_q[i] <= init_px(i);
            py_q[i] <= init_py(i);
            vx_q[i] <= init_vx(i);
            vy_q[i] <= init_vy(i);
         end
         bounce_q       <= '0;
         frame_q        <= '0;
         step_pending_q <= 1'b0;
         rgb_q          <= '0;
      end else begin
         px_q           <= px_d;
         py_q           <= py_d;
         vx_q           <= vx_d;
         vy_q           <= vy_d;
         bounce_q       <= bounce_d;
         frame_q        <= frame_d;
         step_pending_q <= step_pending_d;
         rgb_q          <= rgb_d;
      end
   end

   assign rgb        = rgb_q;
   assign bounce_evt = bounce_q;
   assign frame_cnt  = frame_q;
endmodule
